xnor_reduce_pipe: RTL and testbench



---
 rtl/xnor_reduce_pipe.sv | 168 ++++++++++++++++
 tb/tb_xnor_reduce_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_reduce_pipe.sv
// xnor_reduce_pipe: pipelined radix-3 XNOR/XOR reduction of a WIDTH-bit word.
// Register slices split the tree every LVL_PER_STAGE levels. The slices are
// joined by a valid/ready elastic handshake in which bubbles collapse.
// Optional build macro XNOR_STATS_EN adds CLR/ERR_CNT. ERR_CNT is a saturating
// count of delivered zero results.
module xnor_reduce_pipe #(
  parameter int unsigned WIDTH         = 27,
  parameter int unsigned LVL_PER_STAGE = 1,
  parameter bit          INVERT        = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  output logic             Q,
  output logic             Q_VLD,
  input  logic             Q_RDY
`ifdef XNOR_STATS_EN
  ,
  input  logic             CLR,
  output logic [15:0]      ERR_CNT
`endif
);

  // Number of radix-3 levels needed to cover w leaves (at least one).
  function automatic int unsigned tree_levels(input int unsigned w);
    int unsigned lv;
    int unsigned span;
    lv   = 0;
    span = 1;
    while (span < w) begin
      span = span * 3;
      lv   = lv + 1;
    end
    return (lv == 0) ? 1 : lv;
  endfunction

  // Integer power of three.
  function automatic int unsigned pow3(input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) begin
      r = r * 3;
    end
    return r;
  endfunction

  localparam int unsigned L  = tree_levels(WIDTH);
  localparam int unsigned S  = (L + LVL_PER_STAGE - 1) / LVL_PER_STAGE;
  localparam int unsigned TW = pow3(L);
  localparam int unsigned NW = TW / 3;

  if (WIDTH < 1 || WIDTH > 243 || LVL_PER_STAGE < 1 || LVL_PER_STAGE > 5) begin : g_bad_param
    $error("xnor_reduce_pipe: WIDTH must be 1..243 and LVL_PER_STAGE 1..5");
  end

  // Every slice stores its level vector right-aligned in a TW-bit word; the
  // bits above the live node count are always zero (the XOR identity).
  logic [TW-1:0]         leaf_c;
  logic [S-1:0][TW-1:0]  data_q;
  logic [S-1:0][TW-1:0]  data_d;
  logic [S-1:0][TW-1:0]  src_c;
  logic [S-1:0]          v_q;
  logic [S-1:0]          v_d;
  logic [S-1:0]          vup_c;
  logic [S:0]            rdy_c;

  // Pad the input word to a full tree; unused leaves read as 0.
  assign leaf_c = TW'(IN);

  // Ready chain, slice inputs and next-state data for every slice.
  always_comb begin
    logic [TW-1:0] cur;
    logic [TW-1:0] nxt;
    int            lvl;
    cur    = '0;
    nxt    = '0;
    lvl    = 0;
    v_d    = v_q;
    data_d = data_q;
    src_c  = '0;
    vup_c  = '0;
    rdy_c  = '0;

    // A slice can load when it is empty or its successor is moving on.
    rdy_c[S] = Q_RDY;
    for (int k = int'(S) - 1; k >= 0; k--) begin
      rdy_c[k] = !v_q[k] || rdy_c[k+1];
    end

    // Slice 0 is fed by the port; later slices by their predecessor.
    src_c[0] = leaf_c;
    vup_c[0] = IN_VLD;
    for (int k = 1; k < int'(S); k++) begin
      src_c[k] = data_q[k-1];
      vup_c[k] = v_q[k-1];
    end

    for (int k = 0; k < int'(S); k++) begin
      cur = src_c[k];
      // Reduce up to LVL_PER_STAGE levels; the last slice may have fewer.
      for (int j = 0; j < int'(LVL_PER_STAGE); j++) begin
        lvl = k * int'(LVL_PER_STAGE) + j;
        if (lvl < int'(L)) begin
          nxt = '0;
          for (int i = 0; i < int'(NW); i++) begin
            nxt[i] = cur[3*i] ^ cur[3*i+1] ^ cur[3*i+2];
          end
          cur = nxt;
        end
      end
      // The root node is the only place inversion is applied.
      if (k == int'(S) - 1) begin
        cur[0] = cur[0] ^ INVERT;
      end
      if (rdy_c[k]) begin
        v_d[k] = vup_c[k];
        // Only real words update the data, so an idle output stays put.
        if (vup_c[k]) begin
          data_d[k] = cur;
        end
      end
    end
  end

  // Slice valid bits and data registers; reset discards everything in flight.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      v_q    <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign IN_RDY = rdy_c[0];
  assign Q_VLD  = v_q[S-1];
  assign Q      = data_q[S-1][0];

`ifdef XNOR_STATS_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  // Count delivered zero results; clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (CLR) begin
      err_cnt_d = '0;
    end else if (Q_VLD && Q_RDY && !Q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Statistics counter register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_xnor_reduce_pipe.sv
// Bench for xnor_reduce_pipe: five configurations side by side, a queue-based
// reference model checked every cycle, plus hand-computed pinned expectations.
module tb_xnor_reduce_pipe;

  localparam int NI = 5;

  // Instance configurations: 0 main, 1 three-input cell, 2 single bit,
  // 3 widest with one slice, 4 random sweep.
  function automatic int unsigned cw(input int g);
    case (g)
      0: return 27;
      1: return 3;
      2: return 1;
      3: return 243;
      default: return 100;
    endcase
  endfunction

  function automatic int unsigned cl(input int g);
    case (g)
      3: return 5;
      4: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit ci(input int g);
    return (g == 2) ? 1'b0 : 1'b1;
  endfunction

  // Slice count worked out by hand from ceil(log3(WIDTH)) / LVL_PER_STAGE.
  function automatic int unsigned cs(input int g);
    case (g)
      0: return 3;
      4: return 3;
      default: return 1;
    endcase
  endfunction

  logic              clk = 1'b0;
  logic              rstb;
  logic [242:0]      din [NI];
  logic [NI-1:0]     vld;
  logic [NI-1:0]     rdy;
  logic [NI-1:0]     irdy;
  logic [NI-1:0]     q;
  logic [NI-1:0]     qv;
`ifdef XNOR_STATS_EN
  logic [NI-1:0]     clr;
  logic [15:0]       errc [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    xnor_reduce_pipe #(
      .WIDTH        (cw(g)),
      .LVL_PER_STAGE(cl(g)),
      .INVERT       (ci(g))
    ) u_dut (
      .CLK    (clk),
      .RSTB   (rstb),
      .IN     (din[g][cw(g)-1:0]),
      .IN_VLD (vld[g]),
      .IN_RDY (irdy[g]),
      .Q      (q[g]),
      .Q_VLD  (qv[g]),
      .Q_RDY  (rdy[g])
`ifdef XNOR_STATS_EN
      ,
      .CLR    (clr[g]),
      .ERR_CNT(errc[g])
`endif
    );
  end

  typedef struct {
    int unsigned cyc;
    int          g;
    bit          is_err;
    bit          exp_qv;
    bit          exp_q;
    logic [15:0] exp_err;
    string       name;
  } pin_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  bit          expq [NI][$];
  int unsigned accq [NI][$];
  pin_t        pins [$];
  int          pin_rd = 0;
  bit          end_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reduction result straight from the definition: parity of the used bits.
  function automatic bit model_q(input int g, input logic [242:0] d);
    bit p;
    p = 1'b0;
    for (int i = 0; i < int'(cw(g)); i++) p ^= d[i];
    return p ^ ci(g);
  endfunction

  task automatic check(input string nm, input int g, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h want=%0h cyc=%0d", nm, g, act, exp, cyc);
    end
  endtask

  // Compare process: model and pinned expectations, sampled mid-cycle.
  always @(negedge clk) begin : p_cmp
    bit   exp_rdy;
    bit   exp_vld;
    pin_t p;
    if (!rstb) begin
      for (int g = 0; g < NI; g++) begin
        check("reset_q_vld", g, 16'(qv[g]), 16'd0);
        check("reset_q", g, 16'(q[g]), 16'd0);
        check("reset_in_rdy", g, 16'(irdy[g]), 16'd1);
`ifdef XNOR_STATS_EN
        check("reset_err_cnt", g, errc[g], 16'd0);
`endif
        expq[g].delete();
        accq[g].delete();
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        exp_rdy = !((expq[g].size() == int'(cs(g))) && !rdy[g]);
        check("in_rdy", g, 16'(irdy[g]), 16'(exp_rdy));
        exp_vld = (expq[g].size() > 0) && ((cyc - accq[g][0]) >= cs(g));
        check("q_vld", g, 16'(qv[g]), 16'(exp_vld));
        if (qv[g] && expq[g].size() > 0) begin
          check("q_data", g, 16'(q[g]), 16'(expq[g][0]));
          if (rdy[g]) begin
            void'(expq[g].pop_front());
            void'(accq[g].pop_front());
          end
        end
        if (vld[g] && irdy[g]) begin
          expq[g].push_back(model_q(g, din[g]));
          accq[g].push_back(cyc);
        end
      end
      while (pin_rd < pins.size() && pins[pin_rd].cyc <= cyc) begin
        p = pins[pin_rd];
        if (p.cyc != cyc) begin
          check({p.name, "_missed"}, p.g, 16'(cyc), 16'(p.cyc));
        end else if (p.is_err) begin
`ifdef XNOR_STATS_EN
          check(p.name, p.g, errc[p.g], p.exp_err);
`endif
        end else begin
          check({p.name, "_vld"}, p.g, 16'(qv[p.g]), 16'(p.exp_qv));
          if (p.exp_qv) check(p.name, p.g, 16'(q[p.g]), 16'(p.exp_q));
        end
        pin_rd++;
      end
      if (end_req) begin
        for (int g = 0; g < NI; g++) check("drained", g, 16'(expq[g].size()), 16'd0);
        check("pins_pending", 0, 16'(pins.size() - pin_rd), 16'd0);
      end
    end
  end

  task automatic add_pin(input int unsigned c, input int g, input bit eqv, input bit eq, input string nm);
    pin_t p;
    p.cyc = c; p.g = g; p.is_err = 1'b0; p.exp_qv = eqv; p.exp_q = eq; p.exp_err = '0; p.name = nm;
    pins.push_back(p);
  endtask

  task automatic add_err_pin(input int unsigned c, input logic [15:0] ee, input string nm);
    pin_t p;
    p.cyc = c; p.g = 0; p.is_err = 1'b1; p.exp_qv = 1'b0; p.exp_q = 1'b0; p.exp_err = ee; p.name = nm;
    pins.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : p_stim
    int unsigned c0;
    int          sent;
    logic [7:0]  xnor3_tt;
    logic [242:0] v243 [4];
    bit          r243 [4];
    rstb = 1'b1;
    vld  = '0;
    rdy  = '1;
    for (int g = 0; g < NI; g++) din[g] = '0;
`ifdef XNOR_STATS_EN
    clr = '0;
`endif
    #1 rstb = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    rstb = 1'b1;

    // Directed: 0, 1, all-ones through the 27-bit XNOR with Q_RDY high.
    c0 = cyc;
    vld[0] = 1'b1;
    din[0] = '0;
    add_pin(c0 + 2, 0, 1'b0, 1'b0, "dir_latency");
    add_pin(c0 + 3, 0, 1'b1, 1'b1, "dir_zero");
    tick();
    din[0] = 243'(27'h1);
    add_pin(c0 + 4, 0, 1'b1, 1'b0, "dir_one");
    tick();
    din[0] = 243'(27'h7FF_FFFF);
    add_pin(c0 + 5, 0, 1'b1, 1'b0, "dir_ones");
    tick();
    vld[0] = 1'b0;
    repeat (6) tick();

    // Backpressure: ten words while Q_RDY walks 1,0,0,1.
    sent = 0;
    for (int i = 0; i < 60; i++) begin
      rdy[0] = ((i % 4) == 0) || ((i % 4) == 3);
      vld[0] = (sent < 10);
      din[0] = 243'(27'(32'h0135_79BD * (i + 3)));
      @(negedge clk);
      if (vld[0] && irdy[0]) sent++;
      tick();
    end
    vld[0] = 1'b0;
    rdy[0] = 1'b1;
    repeat (4) tick();

    // Reset mid-flight with three words in the pipeline.
    for (int i = 0; i < 3; i++) begin
      vld[0] = 1'b1;
      din[0] = 243'(27'(i * 5 + 1));
      tick();
    end
    vld[0] = 1'b0;
    #1 rstb = 1'b0;
    #5 rstb = 1'b1;
    tick();
    repeat (6) tick();

    // Single bit, XOR mode.
    c0 = cyc;
    vld[2] = 1'b1;
    din[2] = 243'(1);
    add_pin(c0 + 1, 2, 1'b1, 1'b1, "w1_one");
    tick();
    din[2] = '0;
    add_pin(c0 + 2, 2, 1'b1, 1'b0, "w1_zero");
    tick();
    vld[2] = 1'b0;
    repeat (3) tick();

    // Three-input XNOR truth table, one cycle latency.
    xnor3_tt = 8'h69;
    c0 = cyc;
    for (int n = 0; n < 8; n++) begin
      vld[1] = 1'b1;
      din[1] = 243'(n);
      add_pin(c0 + n + 1, 1, 1'b1, xnor3_tt[n], "xnor3_tt");
      tick();
    end
    vld[1] = 1'b0;
    repeat (3) tick();

    // Widest configuration: a single slice, one cycle latency.
    v243[0] = 243'(1);
    r243[0] = 1'b0;
    v243[1] = '1;
    r243[1] = 1'b0;
    v243[2] = '0;
    v243[2][0] = 1'b1;
    v243[2][242] = 1'b1;
    r243[2] = 1'b1;
    v243[3] = '0;
    r243[3] = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 4; n++) begin
      vld[3] = 1'b1;
      din[3] = v243[n];
      add_pin(c0 + n + 1, 3, 1'b1, r243[n], "w243");
      tick();
    end
    vld[3] = 1'b0;
    repeat (3) tick();

    // Random sweep on the 100-bit, two-levels-per-slice instance.
    for (int i = 0; i < 1000; i++) begin
      vld[4] = 1'($urandom_range(0, 1));
      rdy[4] = ($urandom_range(0, 3) != 0);
      din[4] = 243'({$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    vld[4] = 1'b0;
    rdy[4] = 1'b1;
    repeat (8) tick();

`ifdef XNOR_STATS_EN
    // Clear on the fifth accept: count drops to 0, then resumes.
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    repeat (2) tick();
    c0 = cyc;
    for (int n = 0; n < 5; n++) begin
      vld[0] = 1'b1;
      din[0] = 243'(1);
      clr[0] = (n == 4);
      tick();
    end
    clr[0] = 1'b0;
    vld[0] = 1'b0;
    add_err_pin(c0 + 5, 16'd0, "err_clr");
    add_err_pin(c0 + 6, 16'd1, "err_after_clr");
    add_err_pin(c0 + 8, 16'd3, "err_drain");
    repeat (6) tick();

    // Saturation after 65540 zero results.
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    vld[0] = 1'b1;
    din[0] = 243'(1);
    repeat (65540) tick();
    vld[0] = 1'b0;
    repeat (5) tick();
    add_err_pin(cyc, 16'hFFFF, "err_saturate");
    tick();
`endif

    end_req = 1'b1;
    @(negedge clk);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
